// File: rtl/wb_burst_master_if.sv
// wb_burst_master_if: Wishbone B3 bus bundle between the burst master and its slave
interface wb_burst_master_if #(
    parameter int dw = 32,
    parameter int aw = 32
);
    logic [aw-1:0]   wb_adr_o;
    logic [dw-1:0]   wb_dat_o;
    logic [dw/8-1:0] wb_sel_o;
    logic            wb_we_o;
    logic [2:0]      wb_cti_o;
    logic [1:0]      wb_bte_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic [dw-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;
    logic            wb_rty_i;
    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cti_o, wb_bte_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cti_o, wb_bte_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B3 traffic master issuing single/incrementing bursts with a seed+k data pattern
module wb_burst_master #(
    parameter int dw = 32,
    parameter int aw = 32
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [aw-1:0]   cmd_adr_i,
    input  logic [7:0]      cmd_len_i,
    input  logic [dw-1:0]   cmd_seed_i,
    output logic            done_o,
    output logic            err_o,
    output logic [15:0]     mismatch_cnt_o,
    wb_burst_master_if.master wb
);
    typedef enum logic [1:0] {IDLE, BUS, RETRY, DONE} state_t;

    state_t        state;
    logic [7:0]    k;
    logic [7:0]    len;
    logic [dw-1:0] seed;

    function automatic logic [2:0] cti_f(input logic [7:0] kk, input logic [7:0] ll);
        return ll == 8'd0 ? 3'b000 : kk == ll ? 3'b111 : 3'b010;
    endfunction

    // Command sequencer: accepts a command, walks the beats, handles err/ack/rty in that priority
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state          <= IDLE;
            k              <= '0;
            len            <= '0;
            seed           <= '0;
            cmd_ready_o    <= 1'b1;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
            mismatch_cnt_o <= '0;
            wb.wb_adr_o    <= '0;
            wb.wb_dat_o    <= '0;
            wb.wb_sel_o    <= '0;
            wb.wb_we_o     <= 1'b0;
            wb.wb_cti_o    <= '0;
            wb.wb_bte_o    <= '0;
            wb.wb_cyc_o    <= 1'b0;
            wb.wb_stb_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid_i && cmd_ready_o) begin
                    state          <= BUS;
                    k              <= '0;
                    len            <= cmd_len_i;
                    seed           <= cmd_seed_i;
                    cmd_ready_o    <= 1'b0;
                    err_o          <= 1'b0;
                    mismatch_cnt_o <= '0;
                    wb.wb_adr_o    <= cmd_adr_i & ~aw'(dw/8 - 1);
                    wb.wb_dat_o    <= cmd_we_i ? cmd_seed_i : '0;
                    wb.wb_sel_o    <= '1;
                    wb.wb_we_o     <= cmd_we_i;
                    wb.wb_cti_o    <= cti_f(8'd0, cmd_len_i);
                    wb.wb_cyc_o    <= 1'b1;
                    wb.wb_stb_o    <= 1'b1;
                end
                BUS: if (wb.wb_err_i) begin
                    state       <= DONE;
                    err_o       <= 1'b1;
                    done_o      <= 1'b1;
                    wb.wb_cyc_o <= 1'b0;
                    wb.wb_stb_o <= 1'b0;
                    wb.wb_cti_o <= '0;
                end else if (wb.wb_ack_i) begin
                    if (!wb.wb_we_o && wb.wb_dat_i != seed + dw'(k))
                        mismatch_cnt_o <= mismatch_cnt_o + 16'(mismatch_cnt_o != 16'hFFFF);
                    if (k == len) begin
                        state       <= DONE;
                        done_o      <= 1'b1;
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        wb.wb_cti_o <= '0;
                    end else begin
                        k           <= k + 8'd1;
                        wb.wb_adr_o <= wb.wb_adr_o + aw'(dw/8);
                        wb.wb_dat_o <= wb.wb_we_o ? wb.wb_dat_o + dw'(1) : '0;
                        wb.wb_cti_o <= cti_f(k + 8'd1, len);
                    end
                end else if (wb.wb_rty_i) begin
                    state       <= RETRY;
                    wb.wb_cyc_o <= 1'b0;
                    wb.wb_stb_o <= 1'b0;
                end
                RETRY: begin
                    state       <= BUS;
                    wb.wb_cyc_o <= 1'b1;
                    wb.wb_stb_o <= 1'b1;
                end
                DONE: begin
                    state       <= IDLE;
                    done_o      <= 1'b0;
                    cmd_ready_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: directed tests of the burst master against a behavioural Wishbone memory slave
module tb_wb_burst_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] cmd_seed = '0;
    logic        cmd_ready, done, err;
    logic [15:0] mm;
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    wb_burst_master_if #(.dw(32), .aw(32)) bus ();

    wb_burst_master #(.dw(32), .aw(32)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len), .cmd_seed_i(cmd_seed),
        .done_o(done), .err_o(err), .mismatch_cnt_o(mm), .wb(bus)
    );

    // Slave configuration and state
    int err_beat = -1, rty_beat = -1, corrupt_beat = -1, wmax = 0;
    int beat = 0, wcnt = 0, wdelay = 0;
    bit rty_used = 0;
    logic [31:0] mem [logic [31:0]];

    // Memory slave: responds at the falling edge so the master samples stable inputs
    always @(negedge clk) begin
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_rty_i = 1'b0;
        bus.wb_dat_i = '0;
        if (cmd_ready) begin
            beat = 0;
            rty_used = 0;
        end
        if (bus.wb_cyc_o && bus.wb_stb_o) begin
            if (wcnt < wdelay) wcnt++;
            else begin
                wcnt = 0;
                wdelay = int'($urandom_range(wmax));
                if (beat == err_beat) bus.wb_err_i = 1'b1;
                else if (beat == rty_beat && !rty_used) begin
                    bus.wb_rty_i = 1'b1;
                    rty_used = 1;
                end else begin
                    bus.wb_ack_i = 1'b1;
                    if (bus.wb_we_o) mem[bus.wb_adr_o] = bus.wb_dat_o;
                    else bus.wb_dat_i = (mem.exists(bus.wb_adr_o) ? mem[bus.wb_adr_o] : 32'h0) ^ (beat == corrupt_beat ? 32'h1 : 32'h0);
                    beat++;
                end
            end
        end
    end

    // Bus monitor: logs every responded beat and counts request changes during wait states
    logic [31:0] q_adr[$], q_dat[$];
    logic [2:0]  q_cti[$];
    int          q_kind[$];
    int          unstable = 0;
    bit          wpend = 0;
    logic [31:0] p_adr, p_dat;
    logic [2:0]  p_cti;
    always @(posedge clk) begin
        if (wpend && (!bus.wb_stb_o || bus.wb_adr_o !== p_adr || bus.wb_dat_o !== p_dat || bus.wb_cti_o !== p_cti)) unstable++;
        wpend = !rst && bus.wb_cyc_o && bus.wb_stb_o && !(bus.wb_ack_i || bus.wb_err_i || bus.wb_rty_i);
        p_adr = bus.wb_adr_o;
        p_dat = bus.wb_dat_o;
        p_cti = bus.wb_cti_o;
        if (bus.wb_cyc_o && bus.wb_stb_o && (bus.wb_ack_i || bus.wb_err_i || bus.wb_rty_i)) begin
            q_adr.push_back(bus.wb_adr_o);
            q_dat.push_back(bus.wb_dat_o);
            q_cti.push_back(bus.wb_cti_o);
            q_kind.push_back(bus.wb_err_i ? 1 : bus.wb_ack_i ? 0 : 2);
        end
    end

    int   n_done, low_cyc;
    bit   ready_busy;
    logic first_err, err_at_done, ready_after;
    logic [15:0] mm_at_done;

    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [7:0] len, input logic [31:0] seed);
        q_adr.delete(); q_dat.delete(); q_cti.delete(); q_kind.delete();
        unstable = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_seed = seed;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_done = 1; low_cyc = 0; ready_busy = 0; first_err = err;
        while (!done && n_done < 2000) begin
            if (cmd_ready) ready_busy = 1;
            if (!bus.wb_cyc_o) low_cyc++;
            @(negedge clk);
            n_done++;
        end
        err_at_done = err;
        mm_at_done = mm;
        @(negedge clk);
        ready_after = cmd_ready;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", cmd_ready); else passed++;
        checks++; if ({done, err, mm} !== 18'h0) $display("FAIL reset_status got %h exp 0", {done, err, mm}); else passed++;
        checks++; if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_cti_o, bus.wb_bte_o, bus.wb_sel_o} !== 12'h0) $display("FAIL reset_bus_ctl got %h exp 0", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_cti_o, bus.wb_bte_o, bus.wb_sel_o}); else passed++;
        checks++; if ({bus.wb_adr_o, bus.wb_dat_o} !== 64'h0) $display("FAIL reset_adr_dat got %h exp 0", {bus.wb_adr_o, bus.wb_dat_o}); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        run_cmd(1'b1, 32'h100, 8'd3, 32'hA0);
        checks++; if (n_done !== 5) $display("FAIL wr_done_cycle got %0d exp 5", n_done); else passed++;
        checks++; if (q_adr.size() !== 4) $display("FAIL wr_beats got %0d exp 4", q_adr.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_adr[i] !== 32'h100 + 4 * i || q_dat[i] !== 32'hA0 + i || q_cti[i] !== (i == 3 ? 3'b111 : 3'b010) || q_kind[i] !== 0)
                $display("FAIL wr_beat%0d got adr %h dat %h cti %b kind %0d exp adr %h dat %h", i, q_adr[i], q_dat[i], q_cti[i], q_kind[i], 32'h100 + 4 * i, 32'hA0 + i);
            else passed++;
        end
        checks++; if (ready_busy !== 1'b0) $display("FAIL wr_ready_busy got %b exp 0", ready_busy); else passed++;
        checks++; if (ready_after !== 1'b1) $display("FAIL wr_ready_after got %b exp 1", ready_after); else passed++;
        checks++; if (bus.wb_we_o !== 1'b1) $display("FAIL wr_we got %b exp 1", bus.wb_we_o); else passed++;
        run_cmd(1'b0, 32'h100, 8'd3, 32'hA0);
        checks++; if (n_done !== 5) $display("FAIL rd_done_cycle got %0d exp 5", n_done); else passed++;
        checks++; if ({err_at_done, mm_at_done} !== 17'h0) $display("FAIL rd_status got err %b mm %0d exp 0 0", err_at_done, mm_at_done); else passed++;
        checks++; if (q_dat.size() !== 4 || q_dat[0] !== 32'h0) $display("FAIL rd_dat_o got n %0d dat %h exp n 4 dat 0", q_dat.size(), q_dat[0]); else passed++;
    endtask

    task automatic test_single;
        run_cmd(1'b1, 32'h203, 8'd0, 32'h5);
        checks++; if (n_done !== 2) $display("FAIL single_done_cycle got %0d exp 2", n_done); else passed++;
        checks++; if (q_adr.size() !== 1 || q_cti[0] !== 3'b000 || q_adr[0] !== 32'h200 || q_dat[0] !== 32'h5)
            $display("FAIL single_beat got n %0d cti %b adr %h dat %h exp 1 000 200 5", q_adr.size(), q_cti[0], q_adr[0], q_dat[0]); else passed++;
    endtask

    task automatic test_wait_corrupt;
        run_cmd(1'b1, 32'h400, 8'd15, 32'h1000);
        checks++; if (mm_at_done !== 16'd0) $display("FAIL wc_write_mm got %0d exp 0", mm_at_done); else passed++;
        wmax = 4; corrupt_beat = 5;
        run_cmd(1'b0, 32'h400, 8'd15, 32'h1000);
        wmax = 0; corrupt_beat = -1;
        checks++; if (mm_at_done !== 16'd1) $display("FAIL wc_mismatch got %0d exp 1", mm_at_done); else passed++;
        checks++; if (unstable !== 0) $display("FAIL wc_stable got %0d exp 0", unstable); else passed++;
        checks++; if (q_adr.size() !== 16) $display("FAIL wc_beats got %0d exp 16", q_adr.size()); else passed++;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (q_adr[i] !== 32'h400 + 4 * i || q_cti[i] !== (i == 15 ? 3'b111 : 3'b010))
                $display("FAIL wc_beat%0d got adr %h cti %b exp adr %h", i, q_adr[i], q_cti[i], 32'h400 + 4 * i);
            else passed++;
        end
    endtask

    task automatic test_error;
        err_beat = 2;
        run_cmd(1'b1, 32'h800, 8'd7, 32'h33);
        err_beat = -1;
        checks++; if (err_at_done !== 1'b1) $display("FAIL err_flag got %b exp 1", err_at_done); else passed++;
        checks++; if (n_done !== 4) $display("FAIL err_done_cycle got %0d exp 4", n_done); else passed++;
        checks++; if (q_kind.size() !== 3 || q_kind[2] !== 1 || q_adr[2] !== 32'h808) $display("FAIL err_beats got n %0d kind %0d adr %h exp 3 1 808", q_kind.size(), q_kind[2], q_adr[2]); else passed++;
        checks++; if (err !== 1'b1) $display("FAIL err_held got %b exp 1", err); else passed++;
        run_cmd(1'b0, 32'h800, 8'd0, 32'h33);
        checks++; if (first_err !== 1'b0) $display("FAIL err_cleared got %b exp 0", first_err); else passed++;
        checks++; if ({err_at_done, mm_at_done} !== 17'h0) $display("FAIL err_next_status got err %b mm %0d exp 0 0", err_at_done, mm_at_done); else passed++;
    endtask

    task automatic test_retry;
        rty_beat = 3;
        run_cmd(1'b1, 32'hC00, 8'd6, 32'h50);
        rty_beat = -1;
        checks++; if (q_kind.size() !== 8) $display("FAIL rty_responses got %0d exp 8", q_kind.size()); else passed++;
        checks++; if (q_kind[3] !== 2 || q_adr[3] !== 32'hC0C || q_kind[4] !== 0 || q_adr[4] !== 32'hC0C || q_cti[4] !== 3'b010 || q_dat[4] !== 32'h53)
            $display("FAIL rty_reissue got kind %0d/%0d adr %h/%h cti %b dat %h exp 2/0 c0c/c0c 010 53", q_kind[3], q_kind[4], q_adr[3], q_adr[4], q_cti[4], q_dat[4]); else passed++;
        checks++; if (low_cyc !== 1) $display("FAIL rty_cyc_low got %0d exp 1", low_cyc); else passed++;
        checks++; if (n_done !== 10) $display("FAIL rty_done_cycle got %0d exp 10", n_done); else passed++;
        checks++; if (q_adr[7] !== 32'hC18 || q_cti[7] !== 3'b111) $display("FAIL rty_last got adr %h cti %b exp c18 111", q_adr[7], q_cti[7]); else passed++;
    endtask

    task automatic test_wrap;
        run_cmd(1'b1, 32'hFFFF_FFFC, 8'd1, 32'hFFFF_FFFF);
        checks++; if (q_adr.size() !== 2 || q_adr[0] !== 32'hFFFF_FFFC || q_adr[1] !== 32'h0)
            $display("FAIL wrap_adr got n %0d adr %h/%h exp 2 fffffffc/0", q_adr.size(), q_adr[0], q_adr[1]); else passed++;
        checks++; if (q_dat[1] !== 32'h0 || q_cti[0] !== 3'b010 || q_cti[1] !== 3'b111) $display("FAIL wrap_dat_cti got dat %h cti %b/%b exp 0 010/111", q_dat[1], q_cti[0], q_cti[1]); else passed++;
    endtask

    task automatic test_reset_mid;
        int n = 0;
        bit saw_done = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h1000; cmd_len = 8'd7; cmd_seed = 32'h77;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!(bus.wb_cyc_o && bus.wb_adr_o == 32'h1010) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (bus.wb_adr_o !== 32'h1010 || bus.wb_cyc_o !== 1'b1) $display("FAIL rstmid_reach got adr %h cyc %b exp 1010 1", bus.wb_adr_o, bus.wb_cyc_o); else passed++;
        #1;
        rst = 1'b1;
        #1;
        checks++; if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_cti_o} !== 5'h0) $display("FAIL rstmid_bus got %b exp 0", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_cti_o}); else passed++;
        checks++; if ({cmd_ready, done, err, mm} !== {1'b1, 18'h0}) $display("FAIL rstmid_status got %h exp %h", {cmd_ready, done, err, mm}, {1'b1, 18'h0}); else passed++;
        checks++; if (bus.wb_adr_o !== 32'h0) $display("FAIL rstmid_adr got %h exp 0", bus.wb_adr_o); else passed++;
        repeat (2) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        checks++; if (saw_done !== 1'b0) $display("FAIL rstmid_no_done got %b exp 0", saw_done); else passed++;
        checks++; if ({cmd_ready, bus.wb_cyc_o} !== 2'b10) $display("FAIL rstmid_idle got %b exp 10", {cmd_ready, bus.wb_cyc_o}); else passed++;
        run_cmd(1'b1, 32'h2000, 8'd0, 32'h9);
        checks++; if (n_done !== 2) $display("FAIL rstmid_recover got %0d exp 2", n_done); else passed++;
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_single;
        test_wait_corrupt;
        test_error;
        test_retry;
        test_wrap;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
